// File: rtl/watchdog_pkg.sv
// Shared types for the result byte stream: regime encoding, receiver FSM states and header tag.
package watchdog_pkg;

  typedef logic [2:0] regime_t;
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_A      = 3'd1;
  localparam rx_state_t RX_B      = 3'd2;
  localparam rx_state_t RX_CHK    = 3'd3;
  localparam rx_state_t RX_COMMIT = 3'd4;

  localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;

endpackage

// File: rtl/result_frame_rx_if.sv
// Result stream bundle: byte input side plus the reassembled frame outputs.
interface result_frame_rx_if #(
  parameter int unsigned WORD_W = 32
);
  import watchdog_pkg::*;

  logic [7:0]        in_byte;
  logic              in_valid;
  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  regime_t           mode;
  logic              frame_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output in_byte, in_valid,
    input  word_a, word_b, mode, frame_valid, frame_err, busy
  );

  modport slave (
    input  in_byte, in_valid,
    output word_a, word_b, mode, frame_valid, frame_err, busy
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter; expired fires on the LIMIT-th consecutive enabled idle tick.
module rx_gap_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  assign expired = ena && tick && !clear && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      if (clear || expired) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_frame_rx.sv
// Reassembles {HDR, word_a, word_b} result frames from the serializer byte stream.
// Optional trailing XOR checksum byte enabled by defining FRAME_CHECKSUM_EN.
module result_frame_rx
  import watchdog_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [4:0]  HDR_TAG        = HDR_TAG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  result_frame_rx_if.slave  rx
);

  localparam int unsigned WordW    = WORD_BYTES * 8;
  localparam int unsigned ByteCntW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  rx_state_t           state_q, state_d;
  regime_t             mode_sh_q, mode_sh_d, mode_q, mode_d;
  logic [WordW-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WordW-1:0]    word_a_q, word_a_d, word_b_q, word_b_d;
  logic [ByteCntW-1:0] cnt_q, cnt_d;
  logic                fv_q, fv_d, fe_q, fe_d;
  logic                in_rx, last_byte, gap_tick, expired;
  logic [WordW-1:0]    b_next;

  assign in_rx     = (state_q != RX_IDLE) && (state_q != RX_COMMIT);
  assign last_byte = (cnt_q == ByteCntW'(WORD_BYTES - 1));
  assign b_next    = {b_sh_q[WordW-9:0], rx.in_byte};
  assign gap_tick  = in_rx && !rx.in_valid;

  rx_gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .clear   (!gap_tick),
    .tick    (gap_tick),
    .expired (expired)
  );

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (rx.in_valid) begin
      chk_d = in_rx ? (chk_q ^ rx.in_byte) : rx.in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (ena) begin
      chk_q <= chk_d;
    end
  end
`endif

  // Outputs are loaded as the final byte is accepted, so they are visible during COMMIT.
  always_comb begin
    state_d   = state_q;
    mode_sh_d = mode_sh_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    word_a_d  = word_a_q;
    word_b_d  = word_b_q;
    mode_d    = mode_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      RX_IDLE, RX_COMMIT: begin
        state_d = RX_IDLE;
        if (rx.in_valid) begin
          if (rx.in_byte[7:3] == HDR_TAG) begin
            mode_sh_d = rx.in_byte[2:0];
            a_sh_d    = '0;
            b_sh_d    = '0;
            cnt_d     = '0;
            state_d   = RX_A;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      RX_A: begin
        if (rx.in_valid) begin
          a_sh_d = {a_sh_q[WordW-9:0], rx.in_byte};
          cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
          if (last_byte) state_d = RX_B;
        end
      end
      RX_B: begin
        if (rx.in_valid) begin
          b_sh_d = b_next;
          cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
          if (last_byte) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = RX_CHK;
`else
            word_a_d = a_sh_q;
            word_b_d = b_next;
            mode_d   = mode_sh_q;
            fv_d     = 1'b1;
            state_d  = RX_COMMIT;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      RX_CHK: begin
        if (rx.in_valid) begin
          if (rx.in_byte == chk_q) begin
            word_a_d = a_sh_q;
            word_b_d = b_sh_q;
            mode_d   = mode_sh_q;
            fv_d     = 1'b1;
            state_d  = RX_COMMIT;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_IDLE;
          end
        end
      end
`endif
      default: state_d = RX_IDLE;
    endcase
    if (expired) begin
      fe_d      = 1'b1;
      state_d   = RX_IDLE;
      mode_sh_d = '0;
      a_sh_d    = '0;
      b_sh_d    = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      mode_sh_q <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      word_a_q  <= '0;
      word_b_q  <= '0;
      mode_q    <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      mode_sh_q <= mode_sh_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      word_a_q  <= word_a_d;
      word_b_q  <= word_b_d;
      mode_q    <= mode_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign rx.word_a      = word_a_q;
  assign rx.word_b      = word_b_q;
  assign rx.mode        = mode_q;
  assign rx.frame_valid = fv_q;
  assign rx.frame_err   = fe_q;
  assign rx.busy        = (state_q != RX_IDLE);

endmodule
